// File: rtl/draw_score_ctl.sv
// Score/serve control stage: detects goals once per frame, runs the PLAY/HOLD/GAME_OVER
// FSM and overlays tally blocks on the RGB stream. Optional macro: WINNER_FLASH_EN.
module draw_score_ctl #(
    parameter int          GOAL_X_LEFT  = 20,
    parameter int          GOAL_X_RIGHT = 1003,
    parameter int          GOAL_Y_TOP   = 284,
    parameter int          GOAL_Y_BOT   = 484,
    parameter int          MAX_SCORE    = 7,
    parameter int          HOLD_FRAMES  = 60,
    parameter logic [11:0] P1_COLOR     = 12'hf_0_0,
    parameter logic [11:0] P2_COLOR     = 12'h0_0_f
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] ball_xpos,
    input  logic [11:0] ball_ypos,
    input  logic        new_game,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [3:0]  score_p1,
    output logic [3:0]  score_p2,
    output logic        goal_pulse,
    output logic        serve_req,
    output logic        game_over
);

    localparam logic [11:0] GX_L      = 12'(GOAL_X_LEFT);
    localparam logic [11:0] GX_R      = 12'(GOAL_X_RIGHT);
    localparam logic [11:0] GY_T      = 12'(GOAL_Y_TOP);
    localparam logic [11:0] GY_B      = 12'(GOAL_Y_BOT);
    localparam logic [3:0]  MAX_S     = 4'(MAX_SCORE);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        HOLD      = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  score_p1_d, score_p2_d;
    logic        pulse_d;
    logic        tick;
    logic        in_mouth, goal_l, goal_r;
    logic        hit_p1, hit_p2, draw_p1, draw_p2;
    logic [11:0] rgb_d;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= MAX_S) ? MAX_S : s + 4'd1;
    endfunction

    // Tally n of a player spans 16 pixels starting at base + step*n.
    function automatic logic tally_hit(input logic [11:0] h, input logic [11:0] v,
                                       input logic [3:0] score, input int base,
                                       input int step);
        logic hit;
        int   x0;
        hit = 1'b0;
        if (v >= 12'd16 && v <= 12'd31) begin
            for (int n = 0; n < 15; n++) begin
                x0 = base + step * n;
                if (n < int'(score) && int'(h) >= x0 && int'(h) <= x0 + 15)
                    hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign tick     = vblnk_in & ~vblnk_out;
    assign in_mouth = (ball_ypos >= GY_T) && (ball_ypos <= GY_B);
    assign goal_l   = in_mouth && (ball_xpos <= GX_L);
    assign goal_r   = in_mouth && (ball_xpos >= GX_R);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        score_p1_d = score_p1;
        score_p2_d = score_p2;
        pulse_d    = 1'b0;
        case (state_q)
            PLAY: begin
                if (tick && (goal_l || goal_r)) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                    // Left mouth wins when both tests pass.
                    if (goal_l) begin
                        score_p2_d = sat_inc(score_p2);
                        state_d    = (score_p2_d == MAX_S) ? GAME_OVER : HOLD;
                    end else begin
                        score_p1_d = sat_inc(score_p1);
                        state_d    = (score_p1_d == MAX_S) ? GAME_OVER : HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (cnt_q == HOLD_LAST) state_d = PLAY;
                    else                    cnt_d   = cnt_q + 16'd1;
                end
            end
            GAME_OVER: begin
                if (new_game) begin
                    score_p1_d = '0;
                    score_p2_d = '0;
                    cnt_d      = '0;
                    state_d    = HOLD;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    assign hit_p1 = tally_hit(hcount_in, vcount_in, score_p1, 32, 24);
    assign hit_p2 = tally_hit(hcount_in, vcount_in, score_p2, 976, -24);

`ifdef WINNER_FLASH_EN
    logic [4:0] flash_cnt;
    logic       blank_win;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)       flash_cnt <= '0;
        else if (tick) flash_cnt <= flash_cnt + 5'd1;
    end

    assign blank_win = (state_q == GAME_OVER) && flash_cnt[4];
    assign draw_p1   = hit_p1 && !(blank_win && score_p1 == MAX_S);
    assign draw_p2   = hit_p2 && !(blank_win && score_p2 == MAX_S);
`else
    assign draw_p1 = hit_p1;
    assign draw_p2 = hit_p2;
`endif

    always_comb begin
        rgb_d = rgb_in;
        if (hblnk_in || vblnk_in) rgb_d = '0;
        else if (draw_p1)         rgb_d = P1_COLOR;
        else if (draw_p2)         rgb_d = P2_COLOR;
    end

    // Output register: everything leaves one cycle after its inputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= PLAY;
            cnt_q      <= '0;
            score_p1   <= '0;
            score_p2   <= '0;
            goal_pulse <= 1'b0;
            serve_req  <= 1'b0;
            game_over  <= 1'b0;
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            score_p1   <= score_p1_d;
            score_p2   <= score_p2_d;
            goal_pulse <= pulse_d;
            serve_req  <= (state_d != PLAY);
            game_over  <= (state_d == GAME_OVER);
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            hblnk_out  <= hblnk_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= rgb_d;
        end
    end

endmodule
